text_buf_arbiter: RTL and testbench

//  Shares the single-port character/colour RAM between the VGA text renderer (read, top priority)
//  and a character writer (valid/ready). Also sequences a full-screen clear sweep.

---
 rtl/text_pkg.sv | 21 ++
 rtl/text_cell_addr.sv | 15 +
 rtl/text_buf_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_text_buf_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, cell layout and FSM state type for the text buffer arbiter
package text_pkg;

    localparam int COLS      = 80;
    localparam int ROWS      = 60;
    localparam int CELLS     = COLS * ROWS;
    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 14;
    localparam int HL_BIT    = 13;
    localparam int COL_LSB   = 7;
    localparam int ASCII_LSB = 0;
    localparam int BLINK_DIV = 25000000;

    localparam logic [DATA_W-1:0] CLR_WORD = 14'h0020;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/text_cell_addr.sv
// rtl/text_cell_addr.sv - combinational (cx, cy) to linear cell address with range flag
module text_cell_addr
    import text_pkg::*;
(
    input  logic [6:0]        cx,
    input  logic [5:0]        cy,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    // The product is formed at ADDR_W width; COLS*ROWS fits, so in-range cells never wrap.
    assign addr     = ADDR_W'(cy) * ADDR_W'(COLS) + ADDR_W'(cx);
    assign in_range = (cx < 7'(COLS)) && (cy < 6'(ROWS));

endmodule

// File: rtl/text_buf_arbiter.sv
// rtl/text_buf_arbiter.sv - char RAM arbiter: renderer reads, writer handshake, clear sweep (optional CURSOR_EN)
module text_buf_arbiter
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [6:0]        rd_cx,
    input  logic [5:0]        rd_cy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [6:0]        wr_cx,
    input  logic [5:0]        wr_cy,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_drop,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_addr;
    logic                clr_issue;
    logic                clr_last;
    logic                wr_fire;

    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_in;
    logic [ADDR_W-1:0]   wr_addr;
    logic                wr_in;

    logic                rd_p1;
    logic                rd_p1_oor;
    logic                rd_p2;
    logic                rd_p2_oor;
    logic [DATA_W-1:0]   hl_mask;

    text_cell_addr u_rd_addr (
        .cx       (rd_cx),
        .cy       (rd_cy),
        .addr     (rd_addr),
        .in_range (rd_in)
    );

    text_cell_addr u_wr_addr (
        .cx       (wr_cx),
        .cy       (wr_cy),
        .addr     (wr_addr),
        .in_range (wr_in)
    );

    // The renderer always wins; the writer only gets free cycles while no sweep runs.
    assign wr_ready = (state == IDLE) & ~rd_req;
    assign wr_fire  = wr_valid & wr_ready;
    assign clr_busy = (state == CLEAR);
    assign clr_last = (clr_addr == ADDR_W'(CELLS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and clear-write grant; the sweep stalls on renderer cycles.
    always_comb begin
        state_next = state;
        clr_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (!rd_req) begin
                    clr_issue = 1'b1;
                    if (clr_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM port mux, clear address counter and the fixed two-stage read return pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wr_drop   <= 1'b0;
            clr_addr  <= '0;
            rd_p1     <= 1'b0;
            rd_p1_oor <= 1'b0;
            rd_p2     <= 1'b0;
            rd_p2_oor <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            mem_we  <= 1'b0;
            wr_drop <= 1'b0;
            if (rd_req) begin
                // Out-of-range reads leave the RAM untouched and return CLR_WORD later.
                if (rd_in) begin
                    mem_addr <= rd_addr;
                end
            end else if (clr_issue) begin
                mem_we    <= 1'b1;
                mem_addr  <= clr_addr;
                mem_wdata <= CLR_WORD;
                clr_addr  <= clr_last ? '0 : clr_addr + 1'b1;
            end else if (wr_fire) begin
                if (wr_in) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end else begin
                    wr_drop <= 1'b1;
                end
            end

            rd_p1     <= rd_req;
            rd_p1_oor <= ~rd_in;
            rd_p2     <= rd_p1;
            rd_p2_oor <= rd_p1_oor;
            rd_valid  <= rd_p2;
            if (rd_p2) begin
                rd_data <= rd_p2_oor ? CLR_WORD : (mem_rdata ^ hl_mask);
            end
        end
    end

`ifdef CURSOR_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [6:0]         cur_cx;
    logic [5:0]         cur_cy;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               rd_p1_hit;
    logic               rd_p2_hit;

    // Cursor follows the writer; a sweep homes it to (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_cx <= '0;
            cur_cy <= '0;
        end else if (state == IDLE && state_next == CLEAR) begin
            cur_cx <= '0;
            cur_cy <= '0;
        end else if (wr_fire && wr_in) begin
            if (wr_cx == 7'(COLS - 1)) begin
                cur_cx <= '0;
                cur_cy <= (wr_cy == 6'(ROWS - 1)) ? '0 : wr_cy + 1'b1;
            end else begin
                cur_cx <= wr_cx + 1'b1;
                cur_cy <= wr_cy;
            end
        end
    end

    // Blink phase toggles every BLINK_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Cursor hit is decided at request time and travels alongside the read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_p1_hit <= 1'b0;
            rd_p2_hit <= 1'b0;
        end else begin
            rd_p1_hit <= rd_req & rd_in & blink_phase & (rd_cx == cur_cx) & (rd_cy == cur_cy);
            rd_p2_hit <= rd_p1_hit;
        end
    end

    assign hl_mask = DATA_W'(rd_p2_hit) << HL_BIT;
`else
    assign hl_mask = '0;
`endif

endmodule

// File: tb/tb_text_buf_arbiter.sv
// tb/tb_text_buf_arbiter.sv - self-checking bench for text_buf_arbiter with RAM model and shadow reference
module tb_text_buf_arbiter;
    import text_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [6:0]        rd_cx;
    logic [5:0]        rd_cy;
    logic              rd_valid;
    logic [13:0]       rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [6:0]        wr_cx;
    logic [5:0]        wr_cy;
    logic [13:0]       wr_data;
    logic              wr_drop;
    logic              clr_start;
    logic              clr_busy;
    logic [12:0]       mem_addr;
    logic              mem_we;
    logic [13:0]       mem_wdata;
    logic [13:0]       mem_rdata = '0;

    logic [13:0]       ram    [0:8191];
    logic [13:0]       shadow [0:8191];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-first, one cycle latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    text_buf_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_cx     (rd_cx),
        .rd_cy     (rd_cy),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_cx     (wr_cx),
        .wr_cy     (wr_cy),
        .wr_data   (wr_data),
        .wr_drop   (wr_drop),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_req = 1'b0; rd_cx = '0; rd_cy = '0;
        wr_valid = 1'b0; wr_cx = '0; wr_cy = '0; wr_data = '0; clr_start = 1'b0;
        tick(); tick();
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %0b want 0", rd_valid); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %0b want 0", mem_we); else passed++;
        total++; if (clr_busy !== 1'b0) $display("FAIL reset_clr_busy got %0b want 0", clr_busy); else passed++;
        total++; if (wr_drop !== 1'b0) $display("FAIL reset_wr_drop got %0b want 0", wr_drop); else passed++;
        total++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %0b want 1", wr_ready); else passed++;
        total++; if (mem_addr !== 13'd0) $display("FAIL reset_mem_addr got %0d want 0", mem_addr); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        int writes = 0;
        int reads = 0;
        int busy_cycles = 0;
        int next_addr = 0;
        int bad_addr = 0;
        int bad_data = 0;
        int bad_ready = 0;
        bit done = 0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        wr_valid = 1'b1; wr_cx = 7'd1; wr_cy = 6'd1; wr_data = 14'h3fff;
        rd_cx = 7'd0; rd_cy = 6'd0;
        total++; if (clr_busy !== 1'b1) $display("FAIL clear_busy_enter got %0b want 1", clr_busy); else passed++;
        for (int k = 0; k < 6000 && !done; k++) begin
            rd_req = (k % 8 == 0);
            #1;
            if (wr_ready !== 1'b0) bad_ready++;
            if (rd_req) reads++;
            busy_cycles++;
            @(posedge clk); #1;
            if (mem_we === 1'b1) begin
                if (mem_addr !== 13'(next_addr)) bad_addr++;
                if (mem_wdata !== 14'h0020) bad_data++;
                next_addr++;
                writes++;
            end
            if (clr_busy !== 1'b1) done = 1;
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        total++; if (!done) $display("FAIL clear_timeout busy still %0b after 6000 cycles", clr_busy); else passed++;
        total++; if (writes != 4800) $display("FAIL clear_write_count got %0d want 4800", writes); else passed++;
        total++; if (bad_addr != 0) $display("FAIL clear_addr_order got %0d bad want 0", bad_addr); else passed++;
        total++; if (bad_data != 0) $display("FAIL clear_word got %0d bad want 0", bad_data); else passed++;
        total++; if (bad_ready != 0) $display("FAIL clear_wr_ready got %0d high cycles want 0", bad_ready); else passed++;
        total++; if (busy_cycles != 4800 + reads) $display("FAIL clear_busy_len got %0d want %0d", busy_cycles, 4800 + reads); else passed++;
        for (int i = 0; i < 4800; i++) shadow[i] = 14'h0020;
        tick(); tick(); tick();
    endtask

    task automatic test_read_basic();
        logic [13:0] d;
        d = 14'($urandom);
        wr_valid = 1'b1; wr_cx = 7'd3; wr_cy = 6'd2; wr_data = d;
        tick();
        wr_valid = 1'b0;
        shadow[163] = d;
        total++; if (mem_we !== 1'b1 || mem_addr !== 13'd163) $display("FAIL rdb_prewrite we=%0b addr=%0d want 1/163", mem_we, mem_addr); else passed++;
        rd_req = 1'b1; rd_cx = 7'd3; rd_cy = 6'd2;
        tick();
        rd_req = 1'b0;
        total++; if (mem_addr !== 13'd163) $display("FAIL rdb_addr got %0d want 163", mem_addr); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL rdb_we got %0b want 0", mem_we); else passed++;
        tick();
        total++; if (rd_valid !== 1'b0) $display("FAIL rdb_early_valid got %0b want 0", rd_valid); else passed++;
        tick();
        total++; if (rd_valid !== 1'b1) $display("FAIL rdb_valid got %0b want 1", rd_valid); else passed++;
        total++; if (rd_data !== shadow[163]) $display("FAIL rdb_data got %h want %h", rd_data, shadow[163]); else passed++;
        tick();
        total++; if (rd_valid !== 1'b0) $display("FAIL rdb_valid_pulse got %0b want 0", rd_valid); else passed++;
    endtask

    task automatic test_read_vs_write();
        rd_req = 1'b1; rd_cx = 7'd10; rd_cy = 6'd10;
        wr_valid = 1'b1; wr_cx = 7'd5; wr_cy = 6'd0; wr_data = 14'h1041;
        #1;
        total++; if (wr_ready !== 1'b0) $display("FAIL rvw_ready_blocked got %0b want 0", wr_ready); else passed++;
        tick();
        total++; if (mem_we !== 1'b0) $display("FAIL rvw_no_write got %0b want 0", mem_we); else passed++;
        rd_req = 1'b0;
        #1;
        total++; if (wr_ready !== 1'b1) $display("FAIL rvw_ready_free got %0b want 1", wr_ready); else passed++;
        tick();
        wr_valid = 1'b0;
        shadow[5] = 14'h1041;
        total++; if (mem_we !== 1'b1 || mem_addr !== 13'd5 || mem_wdata !== 14'h1041)
            $display("FAIL rvw_write we=%0b addr=%0d data=%h want 1/5/1041", mem_we, mem_addr, mem_wdata); else passed++;
        tick(); tick();
    endtask

    task automatic test_out_of_range();
        wr_valid = 1'b1; wr_cx = 7'd80; wr_cy = 6'd0; wr_data = 14'h0155;
        #1;
        total++; if (wr_ready !== 1'b1) $display("FAIL oor_ready got %0b want 1", wr_ready); else passed++;
        tick();
        wr_valid = 1'b0;
        total++; if (mem_we !== 1'b0) $display("FAIL oor_we got %0b want 0", mem_we); else passed++;
        total++; if (wr_drop !== 1'b1) $display("FAIL oor_drop got %0b want 1", wr_drop); else passed++;
        tick();
        total++; if (wr_drop !== 1'b0) $display("FAIL oor_drop_pulse got %0b want 0", wr_drop); else passed++;
        rd_req = 1'b1; rd_cx = 7'd0; rd_cy = 6'd60;
        tick();
        rd_req = 1'b0;
        total++; if (mem_we !== 1'b0) $display("FAIL oor_read_we got %0b want 0", mem_we); else passed++;
        tick();
        tick();
        total++; if (rd_valid !== 1'b1 || rd_data !== 14'h0020)
            $display("FAIL oor_read valid=%0b data=%h want 1/0020", rd_valid, rd_data); else passed++;
        tick();
    endtask

    task automatic test_reset_during_clear();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (100) tick();
        total++; if (mem_we !== 1'b1 || mem_addr !== 13'd99) $display("FAIL rdc_progress we=%0b addr=%0d want 1/99", mem_we, mem_addr); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (clr_busy !== 1'b0) $display("FAIL rdc_busy got %0b want 0", clr_busy); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL rdc_we got %0b want 0", mem_we); else passed++;
        total++; if (wr_ready !== 1'b1) $display("FAIL rdc_idle_ready got %0b want 1", wr_ready); else passed++;
        tick();
        total++; if (clr_busy !== 1'b0 || mem_we !== 1'b0) $display("FAIL rdc_stays_idle busy=%0b we=%0b want 0/0", clr_busy, mem_we); else passed++;
        tick(); tick();
    endtask

    task automatic test_random();
        bit          qv[$];
        logic [13:0] qd[$];
        qv.push_back(1'b0); qd.push_back('0);
        qv.push_back(1'b0); qd.push_back('0);
        for (int n = 0; n < 400; n++) begin
            int  rcx, rcy, wcx, wcy, ra, wa;
            bit  r, wv, rin, win, acc;
            logic [13:0] wd;
            r   = ($urandom_range(0, 2) == 0);
            rcx = $urandom_range(0, 84);
            rcy = $urandom_range(0, 63);
            wv  = ($urandom_range(0, 1) == 1);
            wcx = $urandom_range(0, 84);
            wcy = $urandom_range(0, 63);
            wd  = 14'($urandom);
            rin = (rcx < 80) && (rcy < 60);
            win = (wcx < 80) && (wcy < 60);
            ra  = rcy * 80 + rcx;
            wa  = wcy * 80 + wcx;
            acc = wv && !r;
            rd_req = r; rd_cx = 7'(rcx); rd_cy = 6'(rcy);
            wr_valid = wv; wr_cx = 7'(wcx); wr_cy = 6'(wcy); wr_data = wd;
            #1;
            total++; if (wr_ready !== !r) $display("FAIL rnd_ready n=%0d got %0b want %0b", n, wr_ready, !r); else passed++;
            qv.push_back(r);
            qd.push_back(rin ? shadow[ra] : 14'h0020);
            if (acc && win) shadow[wa] = wd;
            @(posedge clk); #1;
            total++; if (mem_we !== (acc && win)) $display("FAIL rnd_we n=%0d got %0b want %0b", n, mem_we, acc && win); else passed++;
            total++; if (wr_drop !== (acc && !win)) $display("FAIL rnd_drop n=%0d got %0b want %0b", n, wr_drop, acc && !win); else passed++;
            if (acc && win) begin
                total++; if (mem_addr !== 13'(wa) || mem_wdata !== wd)
                    $display("FAIL rnd_wr n=%0d addr=%0d data=%h want %0d/%h", n, mem_addr, mem_wdata, wa, wd); else passed++;
            end
            if (r && rin) begin
                total++; if (mem_addr !== 13'(ra)) $display("FAIL rnd_rd_addr n=%0d got %0d want %0d", n, mem_addr, ra); else passed++;
            end
            total++; if (rd_valid !== qv[qv.size() - 3]) $display("FAIL rnd_valid n=%0d got %0b want %0b", n, rd_valid, qv[qv.size() - 3]); else passed++;
            if (qv[qv.size() - 3]) begin
                total++; if (rd_data !== qd[qd.size() - 3]) $display("FAIL rnd_data n=%0d got %h want %h", n, rd_data, qd[qd.size() - 3]); else passed++;
            end
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_read_basic();
        test_read_vs_write();
        test_out_of_range();
        test_reset_during_clear();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
